// File: rtl/ram_sync_pkg.sv
// Shared types and helpers for ram_sync: sweep FSM states, lane count, and
// byte-lane merge of a stored word with incoming write data.
package ram_sync_pkg;

  typedef enum logic {CLEAR, IDLE} state_t;

  // Upper bound on the data word width handled by the merge helper.
  localparam int unsigned MAX_BUS_WIDTH = 256;

  function automatic int unsigned calc_lanes(input int unsigned bus_w,
                                             input int unsigned lane_w);
    return bus_w / lane_w;
  endfunction

  // Lanes with be set take new_w; the rest keep old_w.
  function automatic logic [MAX_BUS_WIDTH-1:0] lane_merge(
      input logic [MAX_BUS_WIDTH-1:0] old_w,
      input logic [MAX_BUS_WIDTH-1:0] new_w,
      input logic [MAX_BUS_WIDTH-1:0] be,
      input int unsigned              lane_w);
    logic [MAX_BUS_WIDTH-1:0] r;
    r = old_w;
    for (int unsigned b = 0; b < MAX_BUS_WIDTH; b++) begin
      if (be[b / lane_w]) r[b] = new_w[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_sync_clear_ctrl.sv
// Clear-sweep controller: walks every address once after reset or on a clr
// request, asserting a zero-write enable while busy.
module ram_clear_ctrl
  import ram_sync_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  output logic                     o_busy,
  output logic                     o_clr_we,
  output logic [ADDRESS_WIDTH-1:0] o_clr_addr
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_cnt;
  logic [ADDRESS_WIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    o_clr_we    = 1'b0;
    case (r_state)
      CLEAR: begin
        o_busy    = 1'b1;
        o_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (i_clr) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ram_sync.sv
// Synchronous RAM with separate write/read ports, per-lane write enables,
// registered read with valid flag, write-first forwarding and a clear sweep.
module ram_sync
  import ram_sync_pkg::*;
#(
  parameter  int unsigned BUS_WIDTH     = 8,
  parameter  int unsigned ADDRESS_WIDTH = 8,
  parameter  int unsigned LANE_WIDTH    = 8,
  localparam int unsigned LANES         = calc_lanes(BUS_WIDTH, LANE_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     busy,
  input  logic [ADDRESS_WIDTH-1:0] wad,
  input  logic                     st,
  input  logic [LANES-1:0]         be,
  input  logic [BUS_WIDTH-1:0]     X,
  input  logic [ADDRESS_WIDTH-1:0] rad,
  input  logic                     rd,
  output logic [BUS_WIDTH-1:0]     O,
  output logic                     ov
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

  if (BUS_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane_width
    $error("ram_sync: BUS_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (BUS_WIDTH > MAX_BUS_WIDTH) begin : g_bad_bus_width
    $error("ram_sync: BUS_WIDTH exceeds MAX_BUS_WIDTH");
  end

  logic [BUS_WIDTH-1:0]     r_mem [DEPTH];
  logic                     w_busy;
  logic                     w_clr_we;
  logic [ADDRESS_WIDTH-1:0] w_clr_addr;
  logic                     w_usr_we;
  logic                     w_fwd;
  logic [BUS_WIDTH-1:0]     w_merged;

  ram_clear_ctrl #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (clr),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_addr(w_clr_addr)
  );

  assign busy     = w_busy;
  assign w_usr_we = !w_busy && st;
  assign w_fwd    = w_usr_we && (wad == rad);
  assign w_merged = BUS_WIDTH'(lane_merge(MAX_BUS_WIDTH'(r_mem[wad]),
                                          MAX_BUS_WIDTH'(X),
                                          MAX_BUS_WIDTH'(be),
                                          LANE_WIDTH));

  // The array has no reset; its contents are defined only by the sweep.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_usr_we) begin
      r_mem[wad] <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      O  <= '0;
      ov <= 1'b0;
    end else if (!w_busy && rd) begin
      O  <= w_fwd ? w_merged : r_mem[rad];
      ov <= 1'b1;
    end else begin
      ov <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_sync.sv
// Directed testbench for ram_sync: an 8-bit x 256 instance for sweep, read,
// write, forwarding and clear behaviour, and a 32-bit instance for lane enables.
module tb_ram_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_clr, a_st, a_rd, a_busy, a_ov;
  logic [0:0]  a_be;
  logic [7:0]  a_wad, a_rad, a_X, a_O;

  logic        b_clr, b_st, b_rd, b_busy, b_ov;
  logic [3:0]  b_be;
  logic [3:0]  b_wad, b_rad;
  logic [31:0] b_X, b_O;

  ram_sync #(.BUS_WIDTH(8), .ADDRESS_WIDTH(8), .LANE_WIDTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .busy(a_busy), .wad(a_wad), .st(a_st),
    .be(a_be), .X(a_X), .rad(a_rad), .rd(a_rd), .O(a_O), .ov(a_ov)
  );

  ram_sync #(.BUS_WIDTH(32), .ADDRESS_WIDTH(4), .LANE_WIDTH(8)) u_dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .busy(b_busy), .wad(b_wad), .st(b_st),
    .be(b_be), .X(b_X), .rad(b_rad), .rd(b_rd), .O(b_O), .ov(b_ov)
  );

  typedef struct {
    logic       st;
    logic       be;
    logic [7:0] wad;
    logic [7:0] x;
    logic       rd;
    logic [7:0] rad;
    logic       exp_ov;
    logic [7:0] exp_o;
  } vec_t;

  vec_t tbl [13];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops (bounded) and any ov pulses seen meanwhile.
  task automatic wait_sweep(input string nm);
    int k;
    int nov;
    k = 0;
    nov = 0;
    while (a_busy && k < 400) begin
      step();
      k++;
      if (a_ov) nov++;
    end
    chk({nm, "_len"}, 32'(k), 32'd256);
    chk({nm, "_ov"}, 32'(nov), 32'd0);
  endtask

  task automatic read_all_zero(input string nm);
    int bad;
    int nov;
    bad = 0;
    nov = 0;
    a_st = 1'b0;
    a_rd = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a_rad = 8'(i);
      step();
      if (a_O !== 8'h00) bad++;
      if (a_ov !== 1'b1) nov++;
    end
    a_rd = 1'b0;
    chk({nm, "_data"}, 32'(bad), 32'd0);
    chk({nm, "_ov"}, 32'(nov), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 8'hA5};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 8'h20, 8'h7E, 1'b1, 8'h20, 1'b1, 8'h7E};
    tbl[5]  = '{1'b1, 1'b1, 8'h21, 8'h3C, 1'b1, 8'h20, 1'b1, 8'h7E};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h21, 1'b1, 8'h3C};
    tbl[7]  = '{1'b1, 1'b0, 8'h22, 8'h99, 1'b1, 8'h22, 1'b1, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b1, 8'h00};
    tbl[9]  = '{1'b1, 1'b1, 8'h10, 8'h5A, 1'b1, 8'h21, 1'b1, 8'h3C};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 8'h5A};
    tbl[11] = '{1'b1, 1'b1, 8'h40, 8'h11, 1'b1, 8'h10, 1'b1, 8'h5A};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 1'b1, 8'h11};

    rst = 1'b1;
    a_clr = 1'b0; a_st = 1'b0; a_rd = 1'b0; a_be = 1'b0;
    a_wad = '0; a_rad = '0; a_X = '0;
    b_clr = 1'b0; b_st = 1'b0; b_rd = 1'b0; b_be = '0;
    b_wad = '0; b_rad = '0; b_X = '0;

    #1;
    chk("reset_busy", 32'(a_busy), 32'd1);
    chk("reset_ov", 32'(a_ov), 32'd0);
    chk("reset_O", 32'(a_O), 32'd0);
    repeat (3) step();

    // Requests held during the post-reset sweep must all be ignored.
    a_st = 1'b1; a_be = 1'b1; a_wad = 8'h00; a_X = 8'hFF;
    a_rd = 1'b1; a_rad = 8'h00;
    rst = 1'b0;
    wait_sweep("init_sweep");
    a_st = 1'b0;
    chk("init_sweep_O", 32'(a_O), 32'd0);
    chk("b_sweep_done", 32'(b_busy), 32'd0);
    read_all_zero("init_readall");

    for (int r = 0; r < 13; r++) begin
      a_st = tbl[r].st; a_be = tbl[r].be; a_wad = tbl[r].wad; a_X = tbl[r].x;
      a_rd = tbl[r].rd; a_rad = tbl[r].rad;
      step();
      chk($sformatf("row%0d_ov", r), 32'(a_ov), 32'(tbl[r].exp_ov));
      chk($sformatf("row%0d_O", r), 32'(a_O), 32'(tbl[r].exp_o));
    end
    a_st = 1'b0; a_rd = 1'b0;

    b_st = 1'b1; b_wad = 4'h5; b_X = 32'h11223344; b_be = 4'b1111;
    step();
    b_X = 32'hAABBCCDD; b_be = 4'b0101; b_rd = 1'b1; b_rad = 4'h5;
    step();
    chk("lane_fwd_O", b_O, 32'h11BB33DD);
    chk("lane_fwd_ov", 32'(b_ov), 32'd1);
    b_st = 1'b0;
    step();
    chk("lane_read_O", b_O, 32'h11BB33DD);
    b_st = 1'b1; b_be = 4'b1000; b_X = 32'hFFFFFFFF; b_rad = 4'h6;
    step();
    chk("lane_other_addr_O", b_O, 32'h00000000);
    b_st = 1'b0; b_rad = 4'h5;
    step();
    chk("lane_top_O", b_O, 32'hFFBB33DD);
    b_rd = 1'b0;
    step();
    chk("lane_idle_ov", 32'(b_ov), 32'd0);
    chk("lane_hold_O", b_O, 32'hFFBB33DD);

    a_st = 1'b1; a_be = 1'b1; a_wad = 8'h31; a_X = 8'h12;
    step();
    a_wad = 8'h32; a_X = 8'h34;
    step();
    // clr with a write and a read in the same cycle: both still happen.
    a_clr = 1'b1; a_wad = 8'h30; a_X = 8'hFF; a_rd = 1'b1; a_rad = 8'h31;
    step();
    chk("clr_busy", 32'(a_busy), 32'd1);
    chk("clr_cycle_ov", 32'(a_ov), 32'd1);
    chk("clr_cycle_O", 32'(a_O), 32'h12);
    a_clr = 1'b0; a_wad = 8'h50; a_rad = 8'h30;
    wait_sweep("clr_sweep");
    a_st = 1'b0; a_rd = 1'b0;
    chk("clr_sweep_O_hold", 32'(a_O), 32'h12);
    read_all_zero("clr_readall");

    a_st = 1'b1; a_wad = 8'h10; a_X = 8'h77; a_rd = 1'b1; a_rad = 8'h10;
    step();
    a_st = 1'b0; a_rd = 1'b0;
    chk("pre_rst_O", 32'(a_O), 32'h77);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    repeat (100) step();
    chk("mid_sweep_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(a_busy), 32'd1);
    chk("mid_rst_ov", 32'(a_ov), 32'd0);
    chk("mid_rst_O", 32'(a_O), 32'd0);
    step();
    step();
    a_rd = 1'b1; a_rad = 8'h10;
    rst = 1'b0;
    wait_sweep("rst_sweep");
    a_rd = 1'b0;
    read_all_zero("rst_readall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_sync.md
# ram_sync

Parametrised synchronous memory, the next generation of the team's register-array RAM. Adds separate write and read ports, per-lane write enables, registered read with a valid flag, write-first forwarding, and a hardware clear sweep that zeroes every word after reset or on request. Sits wherever the datapath needs scratch or table storage with deterministic contents after reset.

## Interface
- BUS_WIDTH, 8, data word width; must be a multiple of LANE_WIDTH
- ADDRESS_WIDTH, 8, address width; DEPTH = 1<<ADDRESS_WIDTH words
- LANE_WIDTH, 8, bits per write-enable lane; LANES = BUS_WIDTH/LANE_WIDTH

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  request a clear sweep (sampled only in IDLE)
- busy  out  1  high while clear sweep runs; st/rd ignored
- wad  in  ADDRESS_WIDTH  write address
- st  in  1  write strobe
- be  in  LANES  lane enables; lane i covers X[i*LANE_WIDTH +: LANE_WIDTH]
- X  in  BUS_WIDTH  write data
- rad  in  ADDRESS_WIDTH  read address
- rd  in  1  read strobe
- O  out  BUS_WIDTH  registered read data
- ov  out  1  O valid, one-cycle pulse per accepted read

## Operation
- States: CLEAR, IDLE. rst asserted -> CLEAR, sweep counter = 0.
- CLEAR: each edge writes 0 to word[counter], counter++; on edge writing DEPTH-1 -> IDLE. st, rd, clr ignored; ov = 0.
- IDLE, clr = 1 -> CLEAR next edge, counter = 0; st/rd in that same cycle still performed.
- Write (IDLE, st = 1): lanes with be[i] = 1 take X; other lanes keep old value. be = 0 is a no-op.
- Read (IDLE, rd = 1): O <= word[rad], ov <= 1 on the same edge; otherwise ov <= 0 and O holds.
- Read and write same address same cycle: write-first; O = merged word (new lanes from X, others old).
- Different addresses same cycle: independent.
- Memory array not reset directly; contents defined by sweep only.
- rst mid-sweep: counter restarts at 0, full sweep repeats.

## Timing
- Reset values: busy = 1, ov = 0, O = 0, state CLEAR, counter = 0.
- After rst deasserts: edges 1..DEPTH clear words 0..DEPTH-1; busy falls after edge DEPTH; first st/rd accepted at edge DEPTH+1.
- clr in IDLE at edge n: busy = 1 after edge n, words cleared on edges n+1..n+DEPTH, busy = 0 after edge n+DEPTH.
- Read latency 1: rd at edge n -> O, ov valid after edge n, through edge n+1.
- Write visible to a later read one cycle after st (and same-cycle via forwarding).
- Back-to-back reads every cycle supported; ov stays high.

## Structure
- Package ram_sync_pkg: state enum {CLEAR, IDLE}, LANES computation, lane-mask-merge function (old, new, be).
- Sub-module ram_clear_ctrl: state FSM + ADDRESS_WIDTH-bit sweep counter; outputs busy, clear write enable, clear address. Top muxes clear vs. user write port into the array.
- Elaboration check: BUS_WIDTH % LANE_WIDTH == 0.

## Test plan
- Reset, run DEPTH+2 cycles, read all 256 words -> every O = 0x00, busy fell exactly after edge 256.
- Write 0xA5 to 0x10, rd 0x10 next cycle -> O = 0xA5, ov pulse 1 cycle; rd 0x11 -> O = 0x00.
- BUS_WIDTH=32: word 0x11223344 at 0x05, write X=0xAABBCCDD be=4'b0101 -> read 0x05 gives 0x11BB33DD.
- Same-cycle st+rd to 0x20 with X=0x7E -> O = 0x7E after that edge; separate addresses read old data.
- Fill words, pulse clr with st to 0x30=0xFF in same cycle -> busy 256 cycles, st/rd ignored meanwhile, all words 0 afterwards.
- Assert rst at counter=100 of sweep -> counter restarts, busy stays 1 for full 256 edges after deassert, ov = 0 throughout.
